// File: rtl/execute_unit.sv
// Single-issue execute unit: register file, single-cycle ALU, and a multi-cycle
// restoring unsigned divider sharing one register write port.
module execute_unit #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NREG   = 32,
    parameter int unsigned DIV_EN = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    op_valid_i,
    output logic                    op_ready_o,
    input  logic [3:0]              opcode_i,
    input  logic [$clog2(NREG)-1:0] reg1_sel_i,
    input  logic [$clog2(NREG)-1:0] reg2_sel_i,
    input  logic [$clog2(NREG)-1:0] destination_i,
    input  logic [4:0]              imm5_i,
    input  logic                    use_imm_i,
    input  logic [$clog2(NREG)-1:0] dbg_sel_i,
    output logic [XLEN-1:0]         dbg_data_o,
    output logic [4:0]              psw_o,
    output logic                    done_o
);
    localparam int unsigned RW    = $clog2(NREG);
    localparam int unsigned SW    = $clog2(XLEN);
    localparam int unsigned CW    = $clog2(XLEN + 1);
    localparam int unsigned F_SAT = 4;
    localparam int unsigned F_CY  = 3;
    localparam int unsigned F_OV  = 2;
    localparam int unsigned F_S   = 1;
    localparam int unsigned F_Z   = 0;
    localparam logic [XLEN-1:0] SAT_MAX = {1'b0, {(XLEN-1){1'b1}}};
    localparam logic [XLEN-1:0] SAT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_WB} state_e;

    state_e            state_q, state_d;
    logic              ready_q, ready_d;
    logic              done_q, done_d;
    logic [4:0]        psw_q, psw_d;
    logic [XLEN-1:0]   gr_q [NREG];
    logic              gr_we;
    logic [RW-1:0]     gr_waddr;
    logic [XLEN-1:0]   gr_wdata;
    logic [XLEN-1:0]   quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [RW-1:0]     dest_q, dest_d;
    logic              dz_q, dz_d;

    logic [XLEN-1:0]   op_a, op_b, res;
    logic [XLEN:0]     sum_w, diff_w, shl_w, rem_sh, trial;
    logic              add_ov, sub_ov, accept;
    logic              wr, flg, cy_upd, cy_new, ov_new, sat_set;

    assign op_a = use_imm_i ? {{(XLEN-5){imm5_i[4]}}, imm5_i}
                            : ((reg1_sel_i == '0) ? '0 : gr_q[reg1_sel_i]);
    assign op_b = (reg2_sel_i == '0) ? '0 : gr_q[reg2_sel_i];

    assign sum_w  = {1'b0, op_b} + {1'b0, op_a};
    assign diff_w = {1'b0, op_b} - {1'b0, op_a};
    assign shl_w  = {1'b0, op_b} << op_a[SW-1:0];
    assign add_ov = (op_a[XLEN-1] == op_b[XLEN-1]) & (sum_w[XLEN-1] != op_a[XLEN-1]);
    assign sub_ov = (op_a[XLEN-1] != op_b[XLEN-1]) & (diff_w[XLEN-1] != op_b[XLEN-1]);

    // One restoring-division step: shift in the next dividend bit, trial-subtract.
    assign rem_sh = {rem_q, quo_q[XLEN-1]};
    assign trial  = rem_sh - {1'b0, dvs_q};

    assign accept     = op_valid_i & ready_q;
    assign op_ready_o = ready_q;
    assign done_o     = done_q;
    assign psw_o      = psw_q;
    assign dbg_data_o = (dbg_sel_i == '0) ? '0 : gr_q[dbg_sel_i];

    always_comb begin
        state_d  = state_q;
        done_d   = 1'b0;
        psw_d    = psw_q;
        gr_we    = 1'b0;
        gr_waddr = destination_i;
        gr_wdata = '0;
        quo_d    = quo_q;
        rem_d    = rem_q;
        dvs_d    = dvs_q;
        cnt_d    = cnt_q;
        dest_d   = dest_q;
        dz_d     = dz_q;
        res      = '0;
        wr       = 1'b0;
        flg      = 1'b0;
        cy_upd   = 1'b0;
        cy_new   = 1'b0;
        ov_new   = 1'b0;
        sat_set  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    done_d = 1'b1;
                    case (opcode_i)
                        4'd0: begin res = sum_w[XLEN-1:0];  wr = 1'b1; flg = 1'b1;
                                    cy_upd = 1'b1; cy_new = sum_w[XLEN];  ov_new = add_ov; end
                        4'd1: begin res = diff_w[XLEN-1:0]; wr = 1'b1; flg = 1'b1;
                                    cy_upd = 1'b1; cy_new = diff_w[XLEN]; ov_new = sub_ov; end
                        4'd2: begin res = diff_w[XLEN-1:0]; flg = 1'b1;
                                    cy_upd = 1'b1; cy_new = diff_w[XLEN]; ov_new = sub_ov; end
                        4'd3: begin res = op_b & op_a; wr = 1'b1; flg = 1'b1; end
                        4'd4: begin res = op_b | op_a; wr = 1'b1; flg = 1'b1; end
                        4'd5: begin res = op_b ^ op_a; wr = 1'b1; flg = 1'b1; end
                        4'd6: begin res = op_a;        wr = 1'b1; flg = 1'b1; end
                        4'd7: begin
                            res     = add_ov ? (op_a[XLEN-1] ? SAT_MIN : SAT_MAX) : sum_w[XLEN-1:0];
                            wr      = 1'b1; flg = 1'b1;
                            cy_upd  = 1'b1; cy_new = sum_w[XLEN]; ov_new = add_ov;
                            sat_set = add_ov;
                        end
                        4'd8: begin
                            if (DIV_EN != 0) begin
                                done_d  = 1'b0;
                                dvs_d   = op_a;
                                quo_d   = op_b;
                                rem_d   = '0;
                                cnt_d   = '0;
                                dest_d  = destination_i;
                                dz_d    = (op_a == '0);
                                state_d = (op_a == '0) ? S_WB : S_DIV;
                            end
                        end
                        4'd9: begin res = shl_w[XLEN-1:0]; wr = 1'b1; flg = 1'b1;
                                    cy_upd = 1'b1; cy_new = shl_w[XLEN]; end
                        default: ;
                    endcase
                    if (flg) begin
                        psw_d[F_S]  = res[XLEN-1];
                        psw_d[F_Z]  = (res == '0);
                        psw_d[F_OV] = ov_new;
                    end
                    if (cy_upd)  psw_d[F_CY]  = cy_new;
                    if (sat_set) psw_d[F_SAT] = 1'b1;
                    gr_we    = wr & (destination_i != '0);
                    gr_wdata = res;
                end
            end
            S_DIV: begin
                if (!trial[XLEN]) begin
                    rem_d = trial[XLEN-1:0];
                    quo_d = {quo_q[XLEN-2:0], 1'b1};
                end else begin
                    rem_d = rem_sh[XLEN-1:0];
                    quo_d = {quo_q[XLEN-2:0], 1'b0};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(XLEN - 1)) state_d = S_WB;
            end
            S_WB: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                if (dz_q) begin
                    psw_d[F_OV] = 1'b1;
                end else begin
                    gr_we       = (dest_q != '0);
                    gr_waddr    = dest_q;
                    gr_wdata    = quo_q;
                    psw_d[F_OV] = 1'b0;
                    psw_d[F_S]  = quo_q[XLEN-1];
                    psw_d[F_Z]  = (quo_q == '0);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign ready_d = (state_d == S_IDLE);

    // Reset also aborts any division in flight: state returns to IDLE with no write-back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            psw_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            dest_q  <= '0;
            dz_q    <= 1'b0;
            for (int unsigned i = 0; i < NREG; i++) gr_q[i] <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            psw_q   <= psw_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            dest_q  <= dest_d;
            dz_q    <= dz_d;
            if (gr_we) gr_q[gr_waddr] <= gr_wdata;
        end
    end

endmodule

// File: tb/tb_execute_unit.sv
// Scoreboard bench for execute_unit: issued ops push expected register/flags/done
// cycle; a monitor pops and compares on every done_o pulse.
module tb_execute_unit;
    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;
    localparam int unsigned RW   = 5;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            op_valid_i = 1'b0;
    logic            op_ready_o;
    logic [3:0]      opcode_i = '0;
    logic [RW-1:0]   reg1_sel_i = '0, reg2_sel_i = '0, destination_i = '0;
    logic [4:0]      imm5_i = '0;
    logic            use_imm_i = 1'b0;
    logic [RW-1:0]   dbg_sel_i = '0;
    logic [XLEN-1:0] dbg_data_o;
    logic [4:0]      psw_o;
    logic            done_o;

    execute_unit #(.XLEN(XLEN), .NREG(NREG), .DIV_EN(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .op_valid_i(op_valid_i), .op_ready_o(op_ready_o), .opcode_i(opcode_i),
        .reg1_sel_i(reg1_sel_i), .reg2_sel_i(reg2_sel_i), .destination_i(destination_i),
        .imm5_i(imm5_i), .use_imm_i(use_imm_i),
        .dbg_sel_i(dbg_sel_i), .dbg_data_o(dbg_data_o),
        .psw_o(psw_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [RW-1:0] rsel;
        logic [31:0]   val;
        logic [4:0]    psw;
        int            due;
        string         name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done_o) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_done at cycle %0d: got 1 expected 0", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk({mon_e.name, "_due"}, 32'(cyc), 32'(mon_e.due));
                chk({mon_e.name, "_psw"}, 32'(psw_o), 32'(mon_e.psw));
                dbg_sel_i = mon_e.rsel;
                #1;
                chk({mon_e.name, "_reg"}, dbg_data_o, mon_e.val);
            end
        end
    end

    task automatic issue(input string name, input logic [3:0] opc, input logic [4:0] dst,
                         input logic [4:0] r1, input logic [4:0] r2, input logic ui,
                         input logic [4:0] imm, input logic [4:0] rsel, input logic [31:0] val,
                         input logic [4:0] psw, input int lat, input bit push);
        int guard = 0;
        while (sb.size() != 0 && guard < 200) begin @(negedge clk); guard++; end
        if (guard >= 200) chk({name, "_drain_timeout"}, 32'(sb.size()), 32'd0);
        @(negedge clk);
        guard = 0;
        while (!op_ready_o && guard < 200) begin @(negedge clk); guard++; end
        if (guard >= 200) chk({name, "_ready_timeout"}, 32'(op_ready_o), 32'd1);
        opcode_i = opc; destination_i = dst; reg1_sel_i = r1; reg2_sel_i = r2;
        use_imm_i = ui; imm5_i = imm; op_valid_i = 1'b1;
        @(posedge clk);
        #1;
        op_valid_i = 1'b0;
        if (push) sb.push_back('{rsel, val, psw, cyc - 1 + lat, name});
    endtask

    int lowcnt;
    int guard;

    initial begin
        dbg_sel_i = 5'd5;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(op_ready_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_psw", 32'(psw_o), 32'd0);
        chk("rst_gr", dbg_data_o, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 32'(op_ready_o), 32'd1);

        //     name          opc   dst  r1  r2  imm  value        rsel psw      lat
        issue("mov_neg1",    4'd6, 2,   0,  0,  1, 5'h1F, 2, 32'hFFFFFFFF, 5'b00010, 1, 1);
        issue("add_wrap",    4'd0, 2,   0,  2,  1, 5'h01, 2, 32'h00000000, 5'b01001, 1, 1);
        issue("mov_r3",      4'd6, 3,   0,  0,  1, 5'h03, 3, 32'h00000003, 5'b01000, 1, 1);
        issue("mov_r4",      4'd6, 4,   0,  0,  1, 5'h05, 4, 32'h00000005, 5'b01000, 1, 1);
        issue("sub_borrow",  4'd1, 3,   4,  3,  0, 5'h00, 3, 32'hFFFFFFFE, 5'b01010, 1, 1);
        issue("mov_r3b",     4'd6, 3,   0,  0,  1, 5'h03, 3, 32'h00000003, 5'b01000, 1, 1);
        issue("cmp",         4'd2, 3,   4,  3,  0, 5'h00, 3, 32'h00000003, 5'b01010, 1, 1);
        issue("mov_r7",      4'd6, 7,   0,  0,  1, 5'h01, 7, 32'h00000001, 5'b01000, 1, 1);
        issue("shl31",       4'd9, 7,   0,  7,  1, 5'h1F, 7, 32'h80000000, 5'b00010, 1, 1);
        issue("sub_ov",      4'd1, 7,   0,  7,  1, 5'h01, 7, 32'h7FFFFFFF, 5'b00100, 1, 1);
        issue("satadd",      4'd7, 7,   0,  7,  1, 5'h01, 7, 32'h7FFFFFFF, 5'b10100, 1, 1);
        issue("add_sticky",  4'd0, 2,   0,  2,  1, 5'h01, 2, 32'h00000001, 5'b10000, 1, 1);
        issue("mov_r2_15",   4'd6, 2,   0,  0,  1, 5'h0F, 2, 32'h0000000F, 5'b10000, 1, 1);
        issue("mov_r1_4",    4'd6, 1,   0,  0,  1, 5'h04, 1, 32'h00000004, 5'b10000, 1, 1);
        issue("mov_r3_0",    4'd6, 3,   0,  0,  1, 5'h00, 3, 32'h00000000, 5'b10001, 1, 1);
        issue("divu",        4'd8, 3,   1,  2,  0, 5'h00, 3, 32'h00000003, 5'b10000, 34, 1);

        // While busy, hold a request that must be ignored (MOV 7 -> r5).
        lowcnt = 0; guard = 0;
        opcode_i = 4'd6; destination_i = 5'd5; use_imm_i = 1'b1; imm5_i = 5'd7;
        op_valid_i = 1'b1;
        while (guard < 100) begin
            @(negedge clk);
            if (op_ready_o) break;
            lowcnt++;
            guard++;
        end
        op_valid_i = 1'b0;
        chk("divu_ready_low", 32'(lowcnt), 32'd33);

        issue("r5_untouched",4'd4, 6,   0,  5,  1, 5'h00, 6, 32'h00000000, 5'b10001, 1, 1);
        issue("divu_zero",   4'd8, 3,   0,  2,  0, 5'h00, 3, 32'h00000003, 5'b10101, 2, 1);
        issue("mov_r0",      4'd6, 0,   0,  0,  1, 5'h1F, 0, 32'h00000000, 5'b10010, 1, 1);
        issue("illegal12",   4'd12,3,   0,  2,  1, 5'h05, 3, 32'h00000003, 5'b10010, 1, 1);
        issue("and_imm",     4'd3, 4,   0,  2,  1, 5'h1C, 4, 32'h0000000C, 5'b10000, 1, 1);
        issue("xor_imm",     4'd5, 4,   0,  4,  1, 5'h1F, 4, 32'hFFFFFFF3, 5'b10010, 1, 1);
        issue("add_carry",   4'd0, 6,   0,  2,  1, 5'h1F, 6, 32'h0000000E, 5'b11000, 1, 1);
        issue("shl_zero",    4'd9, 5,   0,  2,  1, 5'h00, 5, 32'h0000000F, 5'b10000, 1, 1);

        // Reset during the 10th divide iteration must abort silently.
        issue("abort_div",   4'd8, 3,   1,  2,  0, 5'h00, 3, 32'h0, 5'b0, 0, 0);
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        dbg_sel_i = 5'd3;
        #1;
        chk("abort_ready", 32'(op_ready_o), 32'd0);
        chk("abort_done", 32'(done_o), 32'd0);
        chk("abort_psw", 32'(psw_o), 32'd0);
        chk("abort_gr", dbg_data_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_abort", 32'(op_ready_o), 32'd1);
        repeat (40) @(negedge clk);
        issue("post_rst_r2", 4'd4, 6,   0,  2,  1, 5'h00, 6, 32'h00000000, 5'b00001, 1, 1);

        guard = 0;
        while (sb.size() != 0 && guard < 200) begin @(negedge clk); guard++; end
        if (guard >= 200) chk("final_drain_timeout", 32'(sb.size()), 32'd0);
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
